// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port among ALU, load and mul/div writeback.
// Define REGFILE_WB_FWD_EN to add the write-to-read forwarding ports.
module regfile_wb_arbiter #(
  parameter int unsigned DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic [2:0]            req_valid,
  input  logic [14:0]           req_addr,
  input  logic [3*DATA_W-1:0]   req_data,
`ifdef REGFILE_WB_FWD_EN
  input  logic [4:0]            rd_addr_a,
  input  logic [4:0]            rd_addr_b,
  output logic [1:0]            fwd_hit,
  output logic [DATA_W-1:0]     fwd_data_a,
  output logic [DATA_W-1:0]     fwd_data_b,
`endif
  output logic [2:0]            req_ready,
  output logic                  wb_we,
  output logic [4:0]            wb_addr,
  output logic [DATA_W-1:0]     wb_data,
  output logic [31:0]           wb_dec
);

  localparam int unsigned NREQ   = 3;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned PTR_W  = 2;

  logic [PTR_W-1:0]  ptr, ptr_nxt, gnt_idx;
  logic [2:0]        sum;
  logic              found;
  logic [ADDR_W-1:0] addr_arr [NREQ];
  logic [DATA_W-1:0] data_arr [NREQ];
  logic [ADDR_W-1:0] gnt_addr;
  logic [DATA_W-1:0] gnt_data;

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign addr_arr[i] = req_addr[i*ADDR_W +: ADDR_W];
    assign data_arr[i] = req_data[i*DATA_W +: DATA_W];
  end

  // Pointer register: highest-priority requester index
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr <= '0;
    else     ptr <= ptr_nxt;
  end

  // Search ptr, ptr+1, ptr+2 (mod 3); stall and reset suppress any grant
  always_comb begin
    found   = 1'b0;
    gnt_idx = ptr;
    sum     = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum = 3'(ptr) + 3'(k);
      if (sum >= 3'd3) sum = sum - 3'd3;
      if (!found && req_valid[2'(sum)] && !stall && !rst) begin
        found   = 1'b1;
        gnt_idx = 2'(sum);
      end
    end
    ptr_nxt = ptr;
    if (found) ptr_nxt = (gnt_idx == 2'd2) ? 2'd0 : gnt_idx + 2'd1;
  end

  // Grant outputs
  always_comb begin
    req_ready = '0;
    gnt_addr  = addr_arr[gnt_idx];
    gnt_data  = data_arr[gnt_idx];
    if (found) req_ready = 3'b001 << gnt_idx;
  end

  // Registered write port; register-0 writes are consumed but never strobed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_we   <= 1'b0;
      wb_addr <= '0;
      wb_data <= '0;
      wb_dec  <= '0;
    end else if (found && gnt_addr != '0) begin
      wb_we   <= 1'b1;
      wb_addr <= gnt_addr;
      wb_data <= gnt_data;
      wb_dec  <= 32'd1 << gnt_addr;
    end else begin
      wb_we   <= 1'b0;
      wb_dec  <= '0;
    end
  end

`ifdef REGFILE_WB_FWD_EN
  always_comb begin
    fwd_hit[0] = wb_we && (wb_addr == rd_addr_a);
    fwd_hit[1] = wb_we && (wb_addr == rd_addr_b);
    fwd_data_a = fwd_hit[0] ? wb_data : '0;
    fwd_data_b = fwd_hit[1] ? wb_data : '0;
  end
`endif

endmodule
